// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: writeback op-type encodings, register-index width and FIFO entry type
package regfile_wb_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_ALU = 2'd1, OP_LOAD = 2'd2, OP_MD = 2'd3} op_type_e;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: WB, mul/div, decode-lookup and register-file write signals of the arbiter
interface regfile_wb_arbiter_if;
  logic [1:0] type_mem3_wb;
  logic [4:0] wb_des;
  logic [31:0] wb_data;
  logic md_issue;
  logic [4:0] md_issue_rd;
  logic md_valid;
  logic [4:0] md_rd;
  logic [31:0] md_data;
  logic md_ready;
  logic [4:0] rs1_sel, rs2_sel, rd_sel;
  logic rs1_busy, rs2_busy, rd_busy;
  logic pipe_hold;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  modport master (
    output type_mem3_wb, wb_des, wb_data, md_issue, md_issue_rd, md_valid, md_rd, md_data,
           rs1_sel, rs2_sel, rd_sel,
    input  md_ready, rs1_busy, rs2_busy, rd_busy, pipe_hold, rf_we, rf_waddr, rf_wdata
  );
  modport slave (
    input  type_mem3_wb, wb_des, wb_data, md_issue, md_issue_rd, md_valid, md_rd, md_data,
           rs1_sel, rs2_sel, rd_sel,
    output md_ready, rs1_busy, rs2_busy, rd_busy, pipe_hold, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_result_fifo: synchronous FIFO of pending {rd, data} mul/div results with full/empty flags
module wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  wb_entry_t wdata,
  input  logic pop,
  output wb_entry_t head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between WB and the mul/div unit.
// Define WB_ARB_BYPASS_EN to let an idle port take a mul/div result in its arrival cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = STARVE_LIMIT[CW-1:0];
  wb_entry_t head, md_entry;
  logic full, empty, pipe_wr, pop, byp, accept, push, hold;
  logic [31:0] busy, busy_n, clr, set;
  logic [CW-1:0] cnt;
  logic [REG_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  assign pipe_wr = bus.type_mem3_wb != OP_IDLE;
  assign pop = !pipe_wr && !empty;
`ifdef WB_ARB_BYPASS_EN
  assign byp = !pipe_wr && empty && bus.md_valid;
`else
  assign byp = 1'b0;
`endif
  // a pop in the same cycle frees the slot a full FIFO would need
  assign bus.md_ready = !full || pop;
  assign accept = bus.md_valid && bus.md_ready;
  assign push = accept && bus.md_rd != '0 && !byp;
  assign md_entry = {bus.md_rd, bus.md_data};
  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .wdata(md_entry),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    sel_addr = pipe_wr ? bus.wb_des : pop ? head.rd : byp ? bus.md_rd : '0;
    sel_data = pipe_wr ? bus.wb_data : pop ? head.data : byp ? bus.md_data : '0;
  end
  assign bus.rf_we = rst_n && sel_addr != '0;
  assign bus.rf_waddr = rst_n ? sel_addr : '0;
  assign bus.rf_wdata = rst_n ? sel_data : '0;
  always_comb begin
    clr = '0;
    set = '0;
    if (pop || byp) clr[pop ? head.rd : bus.md_rd] = 1'b1;
    if (bus.md_issue) set[bus.md_issue_rd] = 1'b1;
    busy_n = ((busy & ~clr) | set) & ~32'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      cnt <= '0;
      hold <= 1'b0;
    end else begin
      busy <= busy_n;
      cnt <= (empty || pop) ? '0 : (cnt == LIMIT) ? cnt : cnt + 1'b1;
      hold <= !empty && (hold || cnt == LIMIT);
    end
  assign bus.rs1_busy = busy[bus.rs1_sel];
  assign bus.rs2_busy = busy[bus.rs2_sel];
  assign bus.rd_busy = busy[bus.rd_sel];
  assign bus.pipe_hold = hold;
  // decode stalls on rd_busy, so a second issue to a pending register is a protocol bug
  assert property (@(posedge clk) disable iff (!rst_n)
    (bus.md_issue && bus.md_issue_rd != '0) |-> !busy[bus.md_issue_rd]);
endmodule
